regfile_scoreboard: RTL and testbench

//  Parametrised register file for the MIPS core with an integrated write-pending scoreboard.

---
 rtl/regfile_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass, a per-register write-pending scoreboard and a registered LED tap.

module regfile_scoreboard_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              resv,
    output logic [DATA_W-1:0] q,
    output logic              pend
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            pend <= 1'b0;
        end else begin
            if (wr) q <= wdata;
            // a new reservation outranks the writeback clearing the same register
            if (resv)    pend <= 1'b1;
            else if (wr) pend <= 1'b0;
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int LED_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [LED_W-1:0]  led_o
);
    localparam logic [31:0] NREGS = NUM_REGS;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pend;
    logic                            wr_ok, resv_ok, hit_1, hit_2;

    // Backed by a real register and not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok   = wr_en && addr_ok(wr_addr);
    assign resv_ok = resv_en && addr_ok(resv_addr);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        regfile_scoreboard_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr_ok && (wr_addr == ADDR_W'(i))),
            .wdata (wr_data),
            .resv  (resv_ok && (resv_addr == ADDR_W'(i))),
            .q     (regs[i]),
            .pend  (pend[i])
        );
    end

    assign hit_1 = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_1);
    assign hit_2 = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_2);

    // A forwarded write satisfies the hazard, so it also masks the pending bit.
    always_comb begin
        rd_data_1 = '0;
        busy_1    = 1'b0;
        if (addr_ok(rd_addr_1)) begin
            rd_data_1 = hit_1 ? wr_data : regs[rd_addr_1];
            busy_1    = pend[rd_addr_1] && !hit_1;
        end
    end

    always_comb begin
        rd_data_2 = '0;
        busy_2    = 1'b0;
        if (addr_ok(rd_addr_2)) begin
            rd_data_2 = hit_2 ? wr_data : regs[rd_addr_2];
            busy_2    = pend[rd_addr_2] && !hit_2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                led_o <= '0;
        else if (addr_ok(dbg_sel)) led_o <= regs[dbg_sel][DATA_W-1 -: LED_W];
        else                       led_o <= '0;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default config plus a 24-register, no-zero-reg,
// no-bypass config, driven with the same inputs and checked against array models.

module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr_1, rd_addr_2, wr_addr, resv_addr, dbg_sel;
    logic        wr_en, resv_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data_1_a, rd_data_2_a, rd_data_1_b, rd_data_2_b;
    logic        busy_1_a, busy_2_a, busy_1_b, busy_2_b;
    logic [7:0]  led_a, led_b;

    always #5 clk = ~clk;

    regfile_scoreboard dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1_a), .rd_data_2(rd_data_2_a),
        .busy_1(busy_1_a), .busy_2(busy_2_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .dbg_sel(dbg_sel), .led_o(led_a)
    );

    regfile_scoreboard #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1_b), .rd_data_2(rd_data_2_b),
        .busy_1(busy_1_b), .busy_2(busy_2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .dbg_sel(dbg_sel), .led_o(led_b)
    );

    // Reference model: one register array and pending array per configuration.
    int          nregs[2] = '{32, 24};
    bit          zr[2]    = '{1'b1, 1'b0};
    bit          byp[2]   = '{1'b1, 1'b0};
    logic [31:0] mreg[2][32];
    bit          mpend[2][32];
    logic [7:0]  mled[2];
    int          checks = 0;
    int          failures = 0;

    function automatic bit vld(input int c, input logic [4:0] a);
        return (int'(a) < nregs[c]) && !(zr[c] && a == 5'd0);
    endfunction

    function automatic bit fwd(input int c, input logic [4:0] a);
        return byp[c] && wr_en && vld(c, wr_addr) && (wr_addr == a);
    endfunction

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        if (!vld(c, a)) return 32'h0;
        if (fwd(c, a))  return wr_data;
        return mreg[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [4:0] a);
        return vld(c, a) && mpend[c][a] && !fwd(c, a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < 2; c++) begin
            logic [31:0] r1, r2;
            logic        b1, b2;
            logic [7:0]  l;
            if (c == 0) begin
                r1 = rd_data_1_a; r2 = rd_data_2_a; b1 = busy_1_a; b2 = busy_2_a; l = led_a;
            end else begin
                r1 = rd_data_1_b; r2 = rd_data_2_b; b1 = busy_1_b; b2 = busy_2_b; l = led_b;
            end
            check($sformatf("cfg%0d rd_data_1", c), r1, exp_rd(c, rd_addr_1));
            check($sformatf("cfg%0d rd_data_2", c), r2, exp_rd(c, rd_addr_2));
            check($sformatf("cfg%0d busy_1", c), 32'(b1), 32'(exp_busy(c, rd_addr_1)));
            check($sformatf("cfg%0d busy_2", c), 32'(b2), 32'(exp_busy(c, rd_addr_2)));
            check($sformatf("cfg%0d led_o", c), 32'(l), 32'(mled[c]));
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[c][r]  = 32'h0;
                    mpend[c][r] = 1'b0;
                end
                mled[c] = 8'h0;
            end else begin
                mled[c] = (int'(dbg_sel) < nregs[c]) ? mreg[c][dbg_sel][31:24] : 8'h0;
                if (wr_en && vld(c, wr_addr)) begin
                    mreg[c][wr_addr]  = wr_data;
                    mpend[c][wr_addr] = 1'b0;
                end
                if (resv_en && vld(c, resv_addr)) mpend[c][resv_addr] = 1'b1;
            end
        end
    endtask

    // Called 1 time unit after inputs were driven on a falling edge.
    task automatic fin_cycle();
        model_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra, r1, r2, dbg;
        logic [31:0] e1, e2;
        logic        b1, b2;
        logic [7:0]  led;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic re, input logic [4:0] ra,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic b1, input logic b2, input logic [7:0] led);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.r1 = r1; v.r2 = r2; v.dbg = dbg; v.e1 = e1; v.e2 = e2;
        v.b1 = b1; v.b2 = b2; v.led = led;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        // Expectations for dut_a, sampled before the edge that applies each row.
        tbl[0]  = mk(0, 1, 12, 32'h55,       1, 12, 5, 7, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 8'hFF);
        tbl[1]  = mk(1, 0, 0,  32'h0,        0, 0,  5, 12, 3, 32'h0, 32'h0, 0, 0, 8'h00);
        tbl[2]  = mk(1, 1, 0,  32'h12345678, 1, 0,  0, 0, 3, 32'h0, 32'h0, 0, 0, 8'h00);
        tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0,  0, 0, 3, 32'h0, 32'h0, 0, 0, 8'h00);
        tbl[4]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 0,  5, 6, 3, 32'hDEADBEEF, 32'h0, 0, 0, 8'h00);
        tbl[5]  = mk(1, 0, 0,  32'h0,        1, 7,  5, 7, 3, 32'hDEADBEEF, 32'h0, 0, 0, 8'h00);
        tbl[6]  = mk(1, 0, 0,  32'h0,        0, 0,  5, 7, 3, 32'hDEADBEEF, 32'h0, 0, 1, 8'h00);
        tbl[7]  = mk(1, 1, 7,  32'hA5,       0, 0,  5, 7, 3, 32'hDEADBEEF, 32'hA5, 0, 0, 8'h00);
        tbl[8]  = mk(1, 0, 0,  32'h0,        0, 0,  5, 7, 3, 32'hDEADBEEF, 32'hA5, 0, 0, 8'h00);
        tbl[9]  = mk(1, 1, 9,  32'h99,       1, 9,  9, 7, 3, 32'h99, 32'hA5, 0, 0, 8'h00);
        tbl[10] = mk(1, 0, 0,  32'h0,        0, 0,  9, 7, 3, 32'h99, 32'hA5, 1, 0, 8'h00);
        tbl[11] = mk(1, 1, 3,  32'hAB000000, 0, 0,  3, 9, 3, 32'hAB000000, 32'h99, 0, 1, 8'h00);
        tbl[12] = mk(1, 0, 0,  32'h0,        0, 0,  3, 9, 3, 32'hAB000000, 32'h99, 0, 1, 8'h00);
        tbl[13] = mk(1, 0, 0,  32'h0,        0, 0,  3, 9, 3, 32'hAB000000, 32'h99, 0, 1, 8'hAB);
        tbl[14] = mk(1, 1, 9,  32'h77,       0, 0,  9, 9, 3, 32'h77, 32'h77, 0, 0, 8'hAB);
        tbl[15] = mk(1, 0, 0,  32'h0,        0, 0,  9, 31, 3, 32'h77, 32'h0, 0, 0, 8'hAB);

        rst_n = 1'b0; wr_en = 1'b0; resv_en = 1'b0; wr_addr = '0; wr_data = '0;
        resv_addr = '0; rd_addr_1 = '0; rd_addr_2 = '0; dbg_sel = '0;
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Fill every register with ones and leave each one reserved.
        for (int i = 0; i < 32; i++) begin
            rst_n = 1'b1; wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hFFFFFFFF;
            resv_en = 1'b1; resv_addr = 5'(i); rd_addr_1 = 5'(i); rd_addr_2 = 5'd0; dbg_sel = 5'd3;
            #1;
            fin_cycle();
        end

        for (int k = 0; k < 16; k++) begin
            rst_n = tbl[k].rst; wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            resv_en = tbl[k].re; resv_addr = tbl[k].ra; rd_addr_1 = tbl[k].r1;
            rd_addr_2 = tbl[k].r2; dbg_sel = tbl[k].dbg;
            #1;
            check($sformatf("vec%0d rd_data_1", k), rd_data_1_a, tbl[k].e1);
            check($sformatf("vec%0d rd_data_2", k), rd_data_2_a, tbl[k].e2);
            check($sformatf("vec%0d busy_1", k), 32'(busy_1_a), 32'(tbl[k].b1));
            check($sformatf("vec%0d busy_2", k), 32'(busy_2_a), 32'(tbl[k].b2));
            check($sformatf("vec%0d led_o", k), 32'(led_a), 32'(tbl[k].led));
            if (k == 3) check("cfgb r0 holds write", rd_data_1_b, 32'h12345678);
            if (k == 4) check("cfgb no bypass", rd_data_1_b, 32'h0);
            if (k == 5) check("cfgb write visible", rd_data_1_b, 32'hDEADBEEF);
            fin_cycle();
        end

        // Address 30 is real in the default file, out of range in the 24-register one.
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h1234; resv_en = 1'b1; resv_addr = 5'd30;
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
        #1;
        fin_cycle();
        wr_en = 1'b0; resv_en = 1'b0; rd_addr_1 = 5'd30; dbg_sel = 5'd30;
        #1;
        check("cfga r30 data", rd_data_1_a, 32'h1234);
        check("cfga r30 busy", 32'(busy_1_a), 32'h1);
        check("cfgb r30 data", rd_data_1_b, 32'h0);
        check("cfgb r30 busy", 32'(busy_1_b), 32'h0);
        fin_cycle();

        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            resv_en   = 1'($urandom_range(0, 1));
            resv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_2 = ($urandom_range(0, 3) == 0) ? resv_addr : 5'($urandom_range(0, 31));
            dbg_sel   = 5'($urandom_range(0, 31));
            #1;
            fin_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
